cpy_milestone1_alu: RTL and testbench

//   Registered 32-bit ALU for the milestone-1 datapath.

---
 rtl/cpy_alu_defs.sv | 16 +
 rtl/cpy_addsub.sv | 24 ++
 rtl/cpy_milestone1_alu.sv | 89 ++++++++
 tb/tb_cpy_milestone1_alu.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpy_alu_defs.sv
// Shared definitions for the milestone-1 ALU: default datapath width and sel opcodes.
// The optional shifter is selected by the CPY_ALU_SHIFT_EN macro in the top level.
package cpy_alu_defs;

    localparam int WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/cpy_addsub.sv
// Shared adder for ADD and SUB: sub=1 inverts opB and injects a carry-in,
// so cout is the no-borrow flag on subtraction.
module cpy_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~opB : opB;
    assign full  = {1'b0, opA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign cout  = full[WIDTH];
    // Overflow when the effective operands agree in sign but the sum does not.
    assign ovf   = (opA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);

endmodule

// File: rtl/cpy_milestone1_alu.sv
// Registered ALU for the milestone-1 datapath: operation mux, zero detect, output flops.
// Define CPY_ALU_SHIFT_EN to build the SLL/SRL shifter; otherwise sel 110/111 yield zero.
import cpy_alu_defs::*;

module cpy_milestone1_alu #(
    parameter int WIDTH = cpy_alu_defs::WIDTH
) (
    input  logic             elk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] res,
    output logic             z,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] res_d, res_q;
    logic             z_d, z_q;
    logic             c_d, c_q;
    logic             v_d, v_q;

    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    logic             as_sub;

    assign as_sub = (sel == ALU_SUB);

    cpy_addsub #(.WIDTH(WIDTH)) u_addsub (
        .opA  (opA),
        .opB  (opB),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

`ifdef CPY_ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] shamt;
    assign shamt = opB[SHW-1:0];
`endif

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (sel)
            ALU_ADD, ALU_SUB: begin
                res_d = as_sum;
                c_d   = as_cout;
                v_d   = as_ovf;
            end
            ALU_AND: res_d = opA & opB;
            ALU_OR:  res_d = opA | opB;
            ALU_NOT: res_d = ~opA;
            ALU_XOR: res_d = opA ^ opB;
`ifdef CPY_ALU_SHIFT_EN
            ALU_SLL: res_d = opA << shamt;
            ALU_SRL: res_d = opA >> shamt;
`endif
            // Unknown sel (and disabled shifts) fall through to a zero result.
            default: res_d = '0;
        endcase
        z_d = (res_d == '0);
    end

    always_ff @(posedge elk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            z_q   <= 1'b1;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            res_q <= res_d;
            z_q   <= z_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

    assign res = res_q;
    assign z   = z_q;
    assign c   = c_q;
    assign v   = v_q;

endmodule

// File: tb/tb_cpy_milestone1_alu.sv
// Scoreboard bench for cpy_milestone1_alu: each driven op pushes a model result,
// which is popped and compared one edge later.
import cpy_alu_defs::*;

module tb_cpy_milestone1_alu;

    logic        elk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [2:0]  sel = 3'b000;
    logic [31:0] res;
    logic        z, c, v;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cpy_milestone1_alu #(.WIDTH(32)) dut (
        .elk   (elk),
        .rst_n (rst_n),
        .opA   (opA),
        .opB   (opB),
        .sel   (sel),
        .res   (res),
        .z     (z),
        .c     (c),
        .v     (v)
    );

    always #5 elk = ~elk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] wide;
        e = '0;
        case (s)
            3'b000: begin
                wide  = {1'b0, a} + {1'b0, b};
                e.res = wide[31:0];
                e.c   = wide[32];
                e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            3'b001: begin
                e.res = a - b;
                e.c   = (a >= b);
                e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: e.res = ~a;
            3'b101: e.res = a ^ b;
`ifdef CPY_ALU_SHIFT_EN
            3'b110: e.res = a << b[4:0];
            3'b111: e.res = a >> b[4:0];
`endif
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    task automatic apply(input string tag, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge elk);
        sel = s;
        opA = a;
        opB = b;
        sb_q.push_back(model(s, a, b));
        @(posedge elk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_res"}, res, e.res);
            check({tag, "_z"}, {31'd0, z}, {31'd0, e.z});
            check({tag, "_c"}, {31'd0, c}, {31'd0, e.c});
            check({tag, "_v"}, {31'd0, v}, {31'd0, e.v});
        end
    endtask

    initial begin
        logic [31:0] edge_vals [6];
        edge_vals = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_001F};

        #7;
        check("rst_res", res, 32'h0);
        check("rst_z", {31'd0, z}, 32'd1);
        check("rst_c", {31'd0, c}, 32'd0);
        check("rst_v", {31'd0, v}, 32'd0);
        @(negedge elk);
        rst_n = 1'b1;

        apply("and_zero", 3'b010, 32'd10, 32'd0);
        apply("or", 3'b011, 32'd15, 32'd7);

        // Mid-cycle async reset: outputs must clear without a clock edge.
        @(posedge elk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_res", res, 32'h0);
        check("arst_z", {31'd0, z}, 32'd1);
        check("arst_c", {31'd0, c}, 32'd0);
        check("arst_v", {31'd0, v}, 32'd0);
        @(negedge elk);
        rst_n = 1'b1;

        apply("not", 3'b100, 32'hFFFF_FFFF, 32'h1234_5678);
        apply("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1);
        apply("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1);
        apply("sub_eq", 3'b001, 32'd5, 32'd5);
        apply("sub_borrow", 3'b001, 32'd3, 32'd5);
        apply("sub_ovf", 3'b001, 32'h8000_0000, 32'h1);
        apply("xor", 3'b101, 32'hA5A5_A5A5, 32'hFFFF_0000);
        apply("srl31", 3'b111, 32'h8000_0000, 32'd31);
        apply("sll0", 3'b110, 32'hDEAD_BEEF, 32'd0);
        apply("sll4", 3'b110, 32'h1234_5678, 32'h0000_0024);
        apply("srl_hi", 3'b111, 32'hF000_0000, 32'hFFFF_FFE4);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                apply("edge_add", 3'b000, edge_vals[i], edge_vals[j]);
                apply("edge_sub", 3'b001, edge_vals[i], edge_vals[j]);
            end
        end

        for (int k = 0; k < 60; k++) begin
            apply("rnd", 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
